// File: rtl/btn_ce_gen.sv
// Push-button front end: synchronizes and debounces a raw button, then emits
// single-clock ce pulses (press plus optional auto-repeat) for the counter chain.
module btn_ce_gen #(
  parameter int DEB_CYCLES = 500000,
  parameter int RPT_EN     = 1,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic Rn,
  input  logic btn,
  output logic ce,
  output logic level,
  output logic held
);

  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int DCNT_W  = $clog2(DEB_CYCLES);
  localparam int RCNT_W  = $clog2(RPT_MAX);

  localparam logic [DCNT_W-1:0] DEB_LAST    = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(RPT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              level_q, level_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              ce_q, ce_d;
  logic              held_q, held_d;
  state_t            state_q, state_d;
  logic              rise, fall;

  always_comb begin
    s1_d    = btn;
    s2_d    = s1_q;
    dcnt_d  = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (dcnt_q == DEB_LAST) begin
        level_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end

    // The FSM reacts to the level change on the same edge that registers it,
    // so the press pulse and held line up with the level rise.
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;

    state_d = state_q;
    rcnt_d  = rcnt_q;
    ce_d    = 1'b0;
    if (fall) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            ce_d    = 1'b1;
            rcnt_d  = '0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (RPT_EN != 0) begin
            if (rcnt_q == DELAY_LAST) begin
              ce_d    = 1'b1;
              rcnt_d  = '0;
              state_d = REPEAT;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (rcnt_q == PERIOD_LAST) begin
            ce_d   = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!Rn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      rcnt_q  <= '0;
      ce_q    <= 1'b0;
      held_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      rcnt_q  <= rcnt_d;
      ce_q    <= ce_d;
      held_q  <= held_d;
      state_q <= state_d;
    end
  end

  assign ce    = ce_q;
  assign level = level_q;
  assign held  = held_q;

endmodule
